int_ctrl: RTL
=============

// Module: int_ctrl
// PURPOSE
//  Clocked, parametrised interrupt controller that replaces the combinational w5300/sl811 INT merge.
//  Synchronises NCHAN active-high sources and latches them as per-channel pending bits (edge or level mode).
//  Applies a per-channel mask and a global enable, then drives the ZX-bus INT line as an open-drain enable.
//  INT is driven either as a level or as a fixed-length pulse.
//  Sits between the chip interrupt pins and the zbus/ports register decode.
// PARAMETERS
//  NCHAN         4   number of interrupt sources, 1..8
//  SYNC_STAGES   2   synchroniser flops per source, >=2
//  PULSE_LEN     32  INT low time in clk cycles in pulse mode, 1..255
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active-high
//  irq_src    in   NCHAN  async sources, polarity already normalised to active-high
//  cfg_wrena  in   1      register write strobe, one clk wide
//  cfg_addr   in   2      register select: 0=MASK 1=MODE 2=PEND 3=CTRL/VEC
//  cfg_wrdata in   8      write data
//  cfg_rddata out  8      read data, combinational from cfg_addr
//  int_ack    in   1      one-clk INT acknowledge (decoded M1+IORQ)
//  zint_oe    out  1      1 = pull ZX INT low (top level drives 1'b0 : 1'bZ)
//  int_req    out  1      internal request, ungated by CTRL.EN (for status and polling)
// BEHAVIOUR
//  Reset: MASK=0, MODE=0 (all level), PEND=0, CTRL=0, synchronisers=0, FSM=IDLE, counter=0;
//   zint_oe=0, int_req=0, cfg_rddata reflects the reset register values.
//  Register bits [7:NCHAN] read 0 and ignore writes.
//  Sync: sN = irq_src after SYNC_STAGES flops; sP = sN delayed one clk; edge = sN & ~sP.
//  PEND[i] update, each clk:
//   - Edge mode (MODE[i]=1): set on edge[i]; cleared by a write of 1 to PEND[i] (addr 2).
//   - Level mode: PEND[i] <= sN[i]; W1C has no lasting effect while the source is high.
//   - Set and clear in the same clk: set wins.
//  Latency: PEND[i] is high at the SYNC_STAGES+1'th rising clk after the first clk that samples irq_src[i]=1.
//  int_req (registered) <= |(PEND & MASK), so it follows PEND by 1 clk.
//  CTRL (addr 3 write): bit0 EN = global INT enable; bit1 PM = pulse mode. Other bits ignored.
//  Level output (PM=0): zint_oe = EN & int_req. The FSM is held in IDLE.
//  Pulse output (PM=1) FSM, 8-bit counter cnt:
//   - IDLE: if EN & int_req, go to PULSE with cnt=PULSE_LEN-1 and zint_oe=1.
//   - PULSE: cnt decrements each clk. On cnt==0 or int_ack, go to HOLD with zint_oe=0.
//   - HOLD: when int_req==0, go to IDLE. A request that persists produces no second pulse.
//  Clearing EN in any state: zint_oe=0 next clk; FSM goes to IDLE; PEND is kept.
//  Writing PM while the FSM is busy forces IDLE; the new mode applies from the next clk.
//  In level mode, int_ack has no effect unless PRIORITY_VEC_EN is defined.
//  rst asserted mid-pulse: all outputs return to reset values on that clk.
// CONFIGURATION
//  PRIORITY_VEC_EN defined:
//   - addr 3 read = {VLD, 4'b0, VEC[2:0]}, where VEC is the lowest-index channel with PEND&MASK set.
//   - VLD = 1 when any such channel exists.
//   - int_ack also clears PEND[VEC] if that channel is in edge mode; a same-clk new edge on it still sets it.
//  PRIORITY_VEC_EN undefined:
//   - addr 3 reads {6'b0, PM, EN}.
//   - int_ack affects only the pulse FSM; PEND is cleared only by W1C.
// TESTING
//  1. Reset, MASK=0x01, CTRL=0x01, irq_src[0] rises.
//     -> zint_oe=1 exactly SYNC_STAGES+2 clks later. Source low -> zint_oe=0 after the same delay.
//  2. MODE=0x02, MASK=0x02, CTRL=0x03, single-clk pulse on irq_src[1].
//     -> PEND=0x02; zint_oe high for 32 clks, then HOLD. Write PEND=0x02 -> IDLE, no second pulse.
//  3. Pulse mode, int_ack asserted at pulse clk 5 -> zint_oe=0 from clk 6; FSM in HOLD.
//  4. Edge channel: W1C of PEND on the same clk as a new edge -> PEND bit stays 1.
//  5. CTRL.EN cleared mid-pulse -> zint_oe=0 next clk, PEND unchanged.
//     rst mid-pulse -> all registers and outputs at reset values.
//  6. PRIORITY_VEC_EN defined, edges on ch2 and ch3, MASK=0x0C.
//     -> addr 3 reads 0x82; int_ack -> reads 0x83; second int_ack -> reads 0x00.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: clocked interrupt controller for the ZX-bus INT line.
// Synchronises NCHAN active-high sources, latches them as pending bits
// (level or edge mode per channel), masks them, and drives INT as an
// open-drain enable, either as a level or as a PULSE_LEN-cycle pulse.
// Optional feature macro: PRIORITY_VEC_EN (priority vector readback on
// addr 3 and acknowledge-clears-pending for edge channels).
module int_ctrl #(
   parameter int NCHAN       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_LEN   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCHAN-1:0] irq_src,
   input  logic             cfg_wrena,
   input  logic [1:0]       cfg_addr,
   input  logic [7:0]       cfg_wrdata,
   output logic [7:0]       cfg_rddata,
   input  logic             int_ack,
   output logic             zint_oe,
   output logic             int_req
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);

   logic [SYNC_STAGES-1:0][NCHAN-1:0] sync_q;
   logic [NCHAN-1:0] s_n;
   logic [NCHAN-1:0] s_p;
   logic [NCHAN-1:0] rise;

   logic [NCHAN-1:0] mask;
   logic [NCHAN-1:0] mode;
   logic [NCHAN-1:0] pend;
   logic [NCHAN-1:0] pend_next;
   logic [NCHAN-1:0] w1c;
   logic [NCHAN-1:0] ack_clr;
   logic [NCHAN-1:0] active;
   logic             en;
   logic             pm;

   logic wr_mask;
   logic wr_mode;
   logic wr_pend;
   logic wr_ctrl;
   logic pm_change;

   state_t     state;
   state_t     state_next;
   logic [7:0] cnt;
   logic [7:0] cnt_next;

   logic       vld;
   logic [2:0] vec;

   assign s_n    = sync_q[SYNC_STAGES-1];
   assign rise   = s_n & ~s_p;
   assign active = pend & mask;

   assign wr_mask   = cfg_wrena && (cfg_addr == 2'd0);
   assign wr_mode   = cfg_wrena && (cfg_addr == 2'd1);
   assign wr_pend   = cfg_wrena && (cfg_addr == 2'd2);
   assign wr_ctrl   = cfg_wrena && (cfg_addr == 2'd3);
   assign pm_change = wr_ctrl && (cfg_wrdata[1] != pm);

   // Source synchroniser chain plus one extra delay stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         s_p    <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
         s_p    <= s_n;
      end
   end

   // Configuration registers: MASK, MODE, CTRL (EN, PM)
   always_ff @(posedge clk) begin
      if (rst) begin
         mask <= '0;
         mode <= '0;
         en   <= 1'b0;
         pm   <= 1'b0;
      end else begin
         if (wr_mask) mask <= cfg_wrdata[NCHAN-1:0];
         if (wr_mode) mode <= cfg_wrdata[NCHAN-1:0];
         if (wr_ctrl) begin
            en <= cfg_wrdata[0];
            pm <= cfg_wrdata[1];
         end
      end
   end

   // Lowest-index pending-and-unmasked channel
   always_comb begin
      vld = 1'b0;
      vec = '0;
      for (int unsigned i = 0; i < NCHAN; i++) begin
         if (!vld && active[i]) begin
            vld = 1'b1;
            vec = 3'(i);
         end
      end
   end

   // Pending-bit next value: level channels track the synchronised source,
   // edge channels set on a rising edge and clear on W1C/ack, set wins
   always_comb begin
      w1c     = wr_pend ? cfg_wrdata[NCHAN-1:0] : '0;
      ack_clr = '0;
`ifdef PRIORITY_VEC_EN
      for (int unsigned i = 0; i < NCHAN; i++) begin
         ack_clr[i] = int_ack && vld && (vec == 3'(i)) && mode[i];
      end
`endif
      pend_next = '0;
      for (int unsigned i = 0; i < NCHAN; i++) begin
         if (mode[i])
            pend_next[i] = rise[i] | (pend[i] & ~(w1c[i] | ack_clr[i]));
         else
            pend_next[i] = s_n[i];
      end
   end

   // Pending register and registered request
   always_ff @(posedge clk) begin
      if (rst) begin
         pend    <= '0;
         int_req <= 1'b0;
      end else begin
         pend    <= pend_next;
         int_req <= |active;
      end
   end

   // Pulse FSM state and counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Pulse FSM next state: held idle when disabled, in level mode, or on a PM change
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (!en || !pm || pm_change) begin
         state_next = S_IDLE;
         cnt_next   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (int_req) begin
                  state_next = S_PULSE;
                  cnt_next   = CNT_LOAD;
               end
            end
            S_PULSE: begin
               if ((cnt == 8'd0) || int_ack) begin
                  state_next = S_HOLD;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt - 8'd1;
               end
            end
            S_HOLD: begin
               if (!int_req) state_next = S_IDLE;
            end
            default: begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // INT drive: EN gates both modes directly so clearing EN drops INT on the next clk
   always_comb begin
      if (pm) zint_oe = en && (state == S_PULSE);
      else    zint_oe = en && int_req;
   end

   // Register readback, unused high bits read as zero
   always_comb begin
      cfg_rddata = '0;
      case (cfg_addr)
         2'd0: cfg_rddata[NCHAN-1:0] = mask;
         2'd1: cfg_rddata[NCHAN-1:0] = mode;
         2'd2: cfg_rddata[NCHAN-1:0] = pend;
         default: begin
`ifdef PRIORITY_VEC_EN
            cfg_rddata = {vld, 4'b0000, vec};
`else
            cfg_rddata = {6'b000000, pm, en};
`endif
         end
      endcase
   end

endmodule
